// File: rtl/fifo_sync_mem.sv
// fifo_sync_mem: DATA_W x DEPTH storage array, one synchronous write port, asynchronous read.
// Revision 1.0
`default_nettype none

module fifo_sync_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count, programmable flags,
// sticky overflow/underflow, synchronous flush and FWFT or registered read. Revision 1.0
`default_nettype none

module fifo_sync_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 1,
    parameter int FWFT   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            pop_data,
    output logic                         pop_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LVL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LVL);

    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     wr_ptr_next;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_next;
    logic [CW-1:0]     count_next;
    logic              overflow_next;
    logic              underflow_next;
    logic [DATA_W-1:0] head_data;

    always_comb begin
        wr_en          = push & (~full | pop);
        rd_en          = pop & ~empty;
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        // Explicit wrap compare keeps non-power-of-two depths correct
        if (wr_en) begin
            wr_ptr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
        end
        count_next     = count + CW'(wr_en) - CW'(rd_en);
        overflow_next  = overflow | (push & full & ~pop);
        underflow_next = underflow | (pop & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= (count_next == CNT_FULL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CNT_AF);
            almost_empty <= (count_next <= CNT_AE);
            overflow     <= overflow_next;
            underflow    <= underflow_next;
        end
    end

    fifo_sync_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en & ~clr),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign pop_data  = head_data;
            assign pop_valid = 1'b0;
        end else begin : g_reg_read
            logic [DATA_W-1:0] data_q;
            logic              valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (clr) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_en;
                    if (rd_en) begin
                        data_q <= head_data;
                    end
                end
            end

            assign pop_data  = data_q;
            assign pop_valid = valid_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: drives a DEPTH=8 FWFT instance and a DEPTH=6 registered-read instance
// with shared directed and random stimulus, checked against a queue-based reference model.
`default_nettype none

module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] push_data = 8'h00;

    logic [7:0] pd0, pd1;
    logic       pv0, pv1, full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1, ov0, ov1, un0, un1;
    logic [3:0] cnt0;
    logic [2:0] cnt1;

    int passed = 0;
    int total  = 0;

    int dep[2] = '{8, 6};
    int afl[2] = '{6, 4};
    int ael[2] = '{1, 2};

    logic [7:0] mq[2][$];
    logic [7:0] expq[2][$];
    logic       mov[2];
    logic       mun[2];
    logic       mv[2];
    logic [7:0] mpd;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_W(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(1), .FWFT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pd0), .pop_valid(pv0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(6), .AF_LVL(4), .AE_LVL(2), .FWFT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pd1), .pop_valid(pv1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            expq[k].delete();
            mov[k] = 1'b0;
            mun[k] = 1'b0;
            mv[k]  = 1'b0;
        end
        mpd = 8'h00;
    endtask

    // Reference: the FIFO is a queue of at most dep[k] words
    task automatic model_step(input logic p, input logic q, input logic [7:0] d, input logic c);
        int n;
        logic [7:0] head;
        for (int k = 0; k < 2; k++) begin
            n = mq[k].size();
            mv[k] = 1'b0;
            if (c) begin
                mq[k].delete();
                mov[k] = 1'b0;
                mun[k] = 1'b0;
                if (k == 1) mpd = 8'h00;
            end else begin
                if (p && n == dep[k] && !q) mov[k] = 1'b1;
                if (q && n == 0) mun[k] = 1'b1;
                if (q && n > 0) begin
                    head = mq[k].pop_front();
                    expq[k].push_back(head);
                    if (k == 1) begin
                        mv[k] = 1'b1;
                        mpd   = head;
                    end
                end
                if (p && (n < dep[k] || q)) mq[k].push_back(d);
            end
        end
    endtask

    task automatic check_flags();
        int n0, n1;
        n0 = mq[0].size();
        n1 = mq[1].size();
        chk("flags0", {full0, empty0, af0, ae0, ov0, un0, pv0, 5'b0, cnt0},
            {n0 == dep[0], n0 == 0, n0 >= afl[0], n0 <= ael[0], mov[0], mun[0], 1'b0, 5'b0, 4'(n0)});
        chk("flags1", {full1, empty1, af1, ae1, ov1, un1, pv1, 6'b0, cnt1},
            {n1 == dep[1], n1 == 0, n1 >= afl[1], n1 <= ael[1], mov[1], mun[1], mv[1], 6'b0, 3'(n1)});
        chk("popdata1", {8'h00, pd1}, {8'h00, mpd});
    endtask

    // Enters and leaves at posedge+2
    task automatic cycle(input logic p, input logic q, input logic [7:0] d, input logic c);
        push      = p;
        pop       = q;
        push_data = d;
        clr       = c;
        model_step(p, q, d, c);
        @(posedge clk);
        #1 check_flags();
        #1;
    endtask

    // Scoreboard monitor: compares whenever a DUT presents a read word
    always @(negedge clk) begin
        if (rst_n && !clr && pop && !empty0) begin
            if (expq[0].size() == 0) begin
                total++;
                $display("FAIL data0: got %h, expected no read at %0t", pd0, $time);
            end else begin
                chk("data0", {8'h00, pd0}, {8'h00, expq[0].pop_front()});
            end
        end
        if (rst_n && pv1) begin
            if (expq[1].size() == 0) begin
                total++;
                $display("FAIL data1: got %h, expected no valid at %0t", pd1, $time);
            end else begin
                chk("data1", {8'h00, pd1}, {8'h00, expq[1].pop_front()});
            end
        end
    end

    initial begin
        logic p, q, c;
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 check_flags();
        #1 rst_n = 1'b1;

        for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        cycle(1'b1, 1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h33, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b1);

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        push = 1'b0;
        pop  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 check_flags();
        @(posedge clk);
        #1 check_flags();
        #1 rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'hE1, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            p = ($urandom_range(99) < (((i / 50) % 2 == 1) ? 80 : 30));
            q = ($urandom_range(99) < (((i / 50) % 2 == 1) ? 30 : 80));
            c = ($urandom_range(96) == 0);
            cycle(p, q, 8'($urandom), c);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("leftover0", 16'(expq[0].size()), 16'h0000);
        chk("leftover1", 16'(expq[1].size()), 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
